serial_to_parallel_demux: RTL and testbench
===========================================

SERIAL_TO_PARALLEL_DEMUX -- requirements
Module: serial_to_parallel_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port serial_valid, input, 1 bit: serial_data holds a valid bit this cycle.
REQ-005 The block SHALL have port serial_data, input, 1 bit: serial bit, LSB of each word first.
REQ-006 The block SHALL have port serial_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-007 The block SHALL have port parallel_valid, output, 1 bit: parallel_data holds a complete word.
REQ-008 The block SHALL have port parallel_data, output, WIDTH bits: the assembled word.
REQ-009 The block SHALL have port parallel_ready, input, 1 bit: downstream accepts the word this cycle.

Function
REQ-010 The block SHALL accept a serial bit only on a cycle where serial_valid and serial_ready are both 1, with no other input changing its state.
REQ-011 The block SHALL write accepted bit k of a word into collect-register position k, with k counted 0..WIDTH-1 by a bit counter of width $clog2(WIDTH).
REQ-012 The block SHALL implement the bit-steering as a 1-to-WIDTH demultiplexer selected by the bit counter; all unselected positions hold.
REQ-013 The block SHALL use FSM states IDLE (bit counter 0, no partial word) and COLLECT (1..WIDTH-1 bits held).
REQ-014 The block SHALL go IDLE->COLLECT on an accepted bit, stay in COLLECT on an accepted non-final bit, and go COLLECT->IDLE on the accepted bit with counter = WIDTH-1.
REQ-015 The block SHALL, on acceptance of the final bit, copy the completed word (including that bit) into the output register and assert parallel_valid on the next cycle; latency from final bit to parallel_valid is 1 cycle.
REQ-016 The block SHALL hold parallel_data and parallel_valid stable while parallel_valid=1 and parallel_ready=0.
REQ-017 The block SHALL clear parallel_valid after any cycle with parallel_valid=1 and parallel_ready=1, unless a new word completes in that same cycle, in which case parallel_valid stays 1 and parallel_data loads the new word.
REQ-018 The block SHALL drive serial_ready combinationally as NOT (counter = WIDTH-1 AND parallel_valid AND NOT parallel_ready); non-final bits are always accepted.
REQ-019 The block SHALL never drop, duplicate, or reorder a bit or a word.
REQ-020 The block SHALL hold all state when serial_valid=0 (gaps of any length are allowed mid-word).
REQ-021 The block SHALL sustain one bit per cycle when parallel_ready is held 1 (no stall at word boundaries).

Reset
REQ-022 The block SHALL, while rst=1, force state IDLE, bit counter 0, collect register 0, parallel_data 0 and parallel_valid 0, regardless of clk.
REQ-023 The block SHALL discard a partial word on reset mid-operation; the first accepted bit after reset release is bit 0 of a new word.
REQ-024 The block SHALL drive serial_ready=1 during and immediately after reset.

Structure
REQ-025 The block SHALL take the FSM state enum (IDLE, COLLECT) from a shared package serdes_pkg, which the future transmitter also uses.
REQ-026 The block SHALL contain one sub-module, demux_1toN (parameter N; inputs d, sel; output N-bit one-hot-enabled y), instantiated once for bit steering.

Verification
REQ-027 The bench SHALL cover this case: WIDTH=8, parallel_ready=1, serial bits 1,0,1,0,0,1,0,1 on consecutive cycles -> parallel_valid=1 with parallel_data=8'hA5 exactly 1 cycle after the 8th bit, for 1 cycle.
REQ-028 The bench SHALL cover this case: 16 consecutive bits forming 8'h3C then 8'hC3, parallel_ready=1 -> serial_ready never 0, words 8'h3C and 8'hC3 in order, 8 cycles apart.
REQ-029 The bench SHALL cover this case: parallel_ready=0, words 8'h3C then 8'hC3 sent -> parallel_data holds 8'h3C; serial_ready=0 while the 8th bit of 8'hC3 is pending; on raising parallel_ready, the 8'h3C handshake completes and 8'hC3 follows with no loss.
REQ-030 The bench SHALL cover this case: word 8'h81 with serial_valid=0 gaps of 3 cycles between bits -> parallel_data=8'h81, one parallel_valid pulse.
REQ-031 The bench SHALL cover this case: rst pulsed asynchronously (not on a clk edge) after 5 bits of a word -> all outputs 0 immediately; the next 8 bits 8'h5A yield parallel_data=8'h5A.
REQ-032 The bench SHALL cover this case: randomized serial_valid/parallel_ready over 1000 words -> received sequence equals sent sequence, checked by a scoreboard.

Source files
------------

// File: rtl/serdes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | serdes_pkg: state encoding and sizing helpers for serdes blocks  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package serdes_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } serdes_state_t;

    localparam int c_min_width = 2;
    localparam int c_max_width = 32;

    // Index width for a WIDTH-position word; never collapses to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1toN.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | demux_1toN: routes d to output y[sel]; all other outputs are 0   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module demux_1toN
    import serdes_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic                    d,
    input  logic [cnt_width(N)-1:0] sel,
    output logic [N-1:0]            y
);

    localparam int SEL_W = cnt_width(N);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_out
            assign y[i] = d & (sel == SEL_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/serial_to_parallel_demux.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | serial_to_parallel_demux: LSB-first serial to WIDTH-bit words    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module serial_to_parallel_demux
    import serdes_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             serial_ready,
    output logic             parallel_valid,
    output logic [WIDTH-1:0] parallel_data,
    input  logic             parallel_ready
);

    localparam int              CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    serdes_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_collect;

    logic             w_at_last;
    logic             w_out_stall;
    logic             w_accept;
    logic             w_final;
    logic [WIDTH-1:0] w_bit_en;
    logic [WIDTH-1:0] w_word;

    assign w_at_last    = (r_state == COLLECT) && (r_cnt == c_last);
    assign w_out_stall  = parallel_valid & ~parallel_ready;
    // Only the final bit can be refused: it is the one that needs the output register.
    assign serial_ready = ~(w_at_last & w_out_stall);
    assign w_accept     = serial_valid & serial_ready;
    assign w_final      = w_accept & w_at_last;

    demux_1toN #(
        .N   (WIDTH)
    ) u_demux (
        .d   (w_accept),
        .sel (r_cnt),
        .y   (w_bit_en)
    );

    // Word as it stands after this cycle's bit, so a completing word includes its last bit.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_steer
            assign w_word[i] = w_bit_en[i] ? serial_data : r_collect[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_collect <= '0;
        end else begin
            r_collect <= w_word;
            if (w_accept) begin
                if (w_final) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= COLLECT;
                    r_cnt   <= r_cnt + c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
        end else if (w_final) begin
            parallel_valid <= 1'b1;
            parallel_data  <= w_word;
        end else if (parallel_valid && parallel_ready) begin
            parallel_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_demux.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_serial_to_parallel_demux: directed + random scoreboard bench  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_serial_to_parallel_demux;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             serial_valid = 1'b0;
    logic             serial_data = 1'b0;
    logic             serial_ready;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int stalls = 0;
    int rx_count = 0;
    bit rand_ready = 1'b0;

    logic [WIDTH-1:0] exp_q[$];
    int               rx_cycle[$];

    serial_to_parallel_demux #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_ready   (serial_ready),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Downstream readiness: randomised only while rand_ready is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) parallel_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold behaviour.
    initial begin
        logic             prev_hold;
        logic [WIDTH-1:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(parallel_valid), 32'd1);
                    check("hold_data", 32'(parallel_data), 32'(prev_data));
                end
                if (parallel_valid && parallel_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(parallel_data), 32'hFFFF_FFFF);
                    end else begin
                        check("word", 32'(parallel_data), 32'(exp_q.pop_front()));
                    end
                    rx_count++;
                    rx_cycle.push_back(cycle);
                end
                prev_hold = parallel_valid & ~parallel_ready;
                prev_data = parallel_data;
            end
        end
    end

    // Present one bit until accepted; inputs change 1 ns after the rising edge.
    task automatic send_bit(input logic b);
        logic acc;
        int   guard;
        guard = 0;
        serial_valid = 1'b1;
        serial_data  = b;
        forever begin
            @(negedge clk);
            acc = serial_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
            guard++;
            if (guard > 2000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        serial_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        serial_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
        exp_q.push_back(w);
        for (int k = 0; k < WIDTH; k++) begin
            if (k != 0 && gap > 0) idle(gap);
            send_bit(w[k]);
        end
    endtask

    initial begin
        int base;

        // Reset state
        #3;
        check("rst_valid", 32'(parallel_valid), 32'd0);
        check("rst_data", 32'(parallel_data), 32'd0);
        check("rst_ready", 32'(serial_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready", 32'(serial_ready), 32'd1);

        // A5 back-to-back, 1-cycle latency, single-cycle pulse
        parallel_ready = 1'b1;
        send_word(8'hA5, 0);
        check("a5_valid", 32'(parallel_valid), 32'd1);
        check("a5_data", 32'(parallel_data), 32'hA5);
        idle(1);
        check("a5_pulse_end", 32'(parallel_valid), 32'd0);
        idle(2);

        // 3C then C3 streamed, no stall, 8 cycles apart
        stalls = 0;
        base   = rx_count;
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        idle(3);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_count", 32'(rx_count - base), 32'd2);
        if (rx_cycle.size() >= 2)
            check("stream_spacing", 32'(rx_cycle[$] - rx_cycle[$-1]), 32'd8);

        // Backpressure: 3C held, final bit of C3 refused until downstream ready
        base = rx_count;
        parallel_ready = 1'b0;
        send_word(8'h3C, 0);
        fork
            send_word(8'hC3, 0);
            begin
                repeat (12) @(posedge clk);
                #1;
                check("bp_valid", 32'(parallel_valid), 32'd1);
                check("bp_data", 32'(parallel_data), 32'h3C);
                check("bp_serial_ready", 32'(serial_ready), 32'd0);
                parallel_ready = 1'b1;
            end
        join
        idle(3);
        check("bp_count", 32'(rx_count - base), 32'd2);

        // 81 with 3-cycle gaps between bits
        base = rx_count;
        send_word(8'h81, 3);
        idle(4);
        check("gap_count", 32'(rx_count - base), 32'd1);

        // Asynchronous reset mid-word
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(parallel_valid), 32'd0);
        check("arst_data", 32'(parallel_data), 32'd0);
        check("arst_ready", 32'(serial_ready), 32'd1);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        base = rx_count;
        send_word(8'h5A, 0);
        check("after_rst_data", 32'(parallel_data), 32'h5A);
        idle(3);
        check("after_rst_count", 32'(rx_count - base), 32'd1);

        // Randomised traffic
        base       = rx_count;
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [WIDTH-1:0] w;
            w = WIDTH'($urandom_range(0, 255));
            exp_q.push_back(w);
            for (int k = 0; k < WIDTH; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_bit(w[k]);
            end
        end
        rand_ready     = 1'b0;
        #1 parallel_ready = 1'b1;
        for (int t = 0; t < 200 && (exp_q.size() != 0 || parallel_valid); t++) idle(1);
        idle(2);
        check("random_drain", 32'(exp_q.size()), 32'd0);
        check("random_count", 32'(rx_count - base), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
